// File: rtl/mult_fxp_pkg.sv
// Shared fixed-point helpers: rounding mode constants, format width helpers
// and saturation limits used by the multiplier and future adders/MACs.
package mult_fxp_pkg;

  localparam int RND_TRUNC   = 0;
  localparam int RND_NEAREST = 1;

  function automatic int int_len(input int wi1, input int wi2);
    return wi1 + wi2;
  endfunction

  function automatic int frc_len(input int wf1, input int wf2);
    return wf1 + wf2;
  endfunction

  // Largest code of a width-bit field: all ones, or 0 followed by ones if signed.
  function automatic logic [63:0] fxp_max(input int width, input logic sgnd);
    logic [63:0] one;
    one = 64'd1;
    return sgnd ? (one << (width - 1)) - one : (one << width) - one;
  endfunction

  function automatic logic [63:0] fxp_min(input int width, input logic sgnd);
    logic [63:0] one;
    one = 64'd1;
    return sgnd ? (one << (width - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/fxp_resize.sv
// Combinational resize of a WI.WF value into WIO.WFO with optional round-half-up
// and overflow flag; define MULT_FXP_SAT_EN to saturate instead of wrap.
module fxp_resize
  import mult_fxp_pkg::*;
#(
  parameter int WI  = 4,
  parameter int WF  = 12,
  parameter int WIO = 3,
  parameter int WFO = 4,
  parameter int RND = RND_TRUNC
) (
  input  logic                 sgn,
  input  logic [WI+WF-1:0]     din,
  output logic [WIO+WFO-1:0]   dout,
  output logic                 ovf
);

  localparam int   W      = WI + WF;
  localparam int   OW     = WIO + WFO;
  localparam int   VW     = WI + 1 + WFO;
  localparam int   WE     = ((WIO > WI + 1) ? WIO : WI + 1) + WFO;
  localparam logic RND_ON = (RND == RND_NEAREST);

  logic [W:0]    dx;
  logic [VW-1:0] v;
  logic [WE-1:0] ext;
  logic [OW-1:0] wrapped;
  logic          ovf_raw;

  // One extra MSB so a rounding carry lands in the integer part, not off the top.
  assign dx = {sgn & din[W-1], din};

  generate
    if (WFO >= WF) begin : g_pad
      assign v = VW'(dx) << (WFO - WF);
    end else begin : g_drop
      localparam int D = WF - WFO;
      logic [W:0] sum;
      assign sum = dx + ((W + 1)'(RND_ON) << (D - 1));
      assign v   = VW'(sum >> D);
    end
  endgenerate

  always_comb begin
    if (sgn) ext = WE'($signed(v));
    else     ext = WE'(v);
  end

  generate
    if (WIO >= WI + 1) begin : g_fit
      assign wrapped = ext;
      assign ovf_raw = 1'b0;
    end else begin : g_cut
      localparam int ND = WE - OW;
      logic [ND-1:0] drop;
      assign drop    = ext[WE-1:OW];
      assign ovf_raw = sgn ? (drop != {ND{ext[OW-1]}}) : (|drop);
      assign wrapped = sgn ? {ext[WE-1], ext[OW-2:0]} : ext[OW-1:0];
    end
  endgenerate

`ifdef MULT_FXP_SAT_EN
  localparam logic [63:0] MAX_U = fxp_max(OW, 1'b0);
  localparam logic [63:0] MAX_S = fxp_max(OW, 1'b1);
  localparam logic [63:0] MIN_S = fxp_min(OW, 1'b1);

  always_comb begin
    dout = wrapped;
    if (ovf_raw) begin
      if (!sgn)           dout = MAX_U[OW-1:0];
      else if (ext[WE-1]) dout = MIN_S[OW-1:0];
      else                dout = MAX_S[OW-1:0];
    end
  end
`else
  assign dout = wrapped;
`endif

  assign ovf = ovf_raw;

endmodule

// File: rtl/mult_fixed_pipe_vld.sv
// Pipelined fixed-point multiplier with valid/ready flow control, per-operand
// signed mode and output resize; MULT_FXP_SAT_EN selects saturating overflow.
module mult_fixed_pipe_vld
  import mult_fxp_pkg::*;
#(
  parameter int WI1 = 2,
  parameter int WF1 = 6,
  parameter int WI2 = 2,
  parameter int WF2 = 6,
  parameter int WIO = 3,
  parameter int WFO = 4,
  parameter int PIP = 4,
  parameter int RND = RND_TRUNC
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic                 sgn,
  input  logic [WI1+WF1-1:0]   in1,
  input  logic [WI2+WF2-1:0]   in2,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [WIO+WFO-1:0]   out,
  output logic                 ovf
);

  localparam int IL = int_len(WI1, WI2);
  localparam int FL = frc_len(WF1, WF2);
  localparam int PW = IL + FL;
  localparam int OW = WIO + WFO;

  logic               en;
  logic [PIP-1:1]     vld;
  logic [WI1+WF1-1:0] a1;
  logic [WI2+WF2-1:0] b1;
  logic               s1;
  logic [PW-1:0]      ax;
  logic [PW-1:0]      bx;
  logic [PW-1:0]      pr [2:PIP-1];
  logic               sg [2:PIP-1];
  logic [OW-1:0]      res_out;
  logic               res_ovf;

  // A held result freezes the whole pipe; bubbles stay where they are.
  assign en     = ~(out_vld & ~out_rdy);
  assign in_rdy = en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld <= '0;
      a1  <= '0;
      b1  <= '0;
      s1  <= 1'b0;
    end else if (en) begin
      vld <= {vld[PIP-2:1], in_vld};
      a1  <= in1;
      b1  <= in2;
      s1  <= sgn;
    end
  end

  // Extending both operands to the product width makes one modular multiply serve both modes.
  always_comb begin
    if (s1) begin
      ax = PW'($signed(a1));
      bx = PW'($signed(b1));
    end else begin
      ax = PW'(a1);
      bx = PW'(b1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 2; k < PIP; k++) begin
        pr[k] <= '0;
        sg[k] <= 1'b0;
      end
    end else if (en) begin
      pr[2] <= ax * bx;
      sg[2] <= s1;
      for (int k = 3; k < PIP; k++) begin
        pr[k] <= pr[k-1];
        sg[k] <= sg[k-1];
      end
    end
  end

  fxp_resize #(
    .WI  (IL),
    .WF  (FL),
    .WIO (WIO),
    .WFO (WFO),
    .RND (RND)
  ) u_resize (
    .sgn  (sg[PIP-1]),
    .din  (pr[PIP-1]),
    .dout (res_out),
    .ovf  (res_ovf)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_vld <= 1'b0;
      out     <= '0;
      ovf     <= 1'b0;
    end else if (en) begin
      out_vld <= vld[PIP-1];
      out     <= res_out;
      ovf     <= res_ovf;
    end
  end

endmodule

// File: tb/tb_mult_fixed_pipe_vld.sv
// Self-checking bench for mult_fixed_pipe_vld: directed vectors plus random
// traffic scored against an arithmetic model; honours MULT_FXP_SAT_EN.
module tb_mult_fixed_pipe_vld;

  localparam int WI1 = 2, WF1 = 6, WI2 = 2, WF2 = 6;
  localparam int WIO = 3, WFO = 4, PIP = 4, RND = 0;
  localparam int W1 = WI1 + WF1;
  localparam int W2 = WI2 + WF2;
  localparam int OW = WIO + WFO;
  localparam int FL = WF1 + WF2;
`ifdef MULT_FXP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic          sgn = 1'b0;
  logic [W1-1:0] in1 = '0;
  logic [W2-1:0] in2 = '0;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [OW-1:0] out;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  logic [OW:0] exp_q [$];

  always #5 CLK = ~CLK;

  mult_fixed_pipe_vld #(
    .WI1(WI1), .WF1(WF1), .WI2(WI2), .WF2(WF2),
    .WIO(WIO), .WFO(WFO), .PIP(PIP), .RND(RND)
  ) dut (
    .CLK(CLK), .RST(RST), .in_vld(in_vld), .in_rdy(in_rdy), .sgn(sgn),
    .in1(in1), .in2(in2), .out_vld(out_vld), .out_rdy(out_rdy),
    .out(out), .ovf(ovf)
  );

  // Real-valued view: q = product scaled to output LSBs, then range-checked.
  function automatic logic [OW:0] model(input logic s, input logic [W1-1:0] a,
                                        input logic [W2-1:0] b);
    longint av, bv, p, q, hi, lo;
    int sh;
    logic o;
    logic [OW-1:0] r;
    av = s ? longint'($signed(a)) : longint'(a);
    bv = s ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    sh = FL - WFO;
    if (sh <= 0) q = p <<< (-sh);
    else         q = (p + ((RND != 0) ? (longint'(1) <<< (sh - 1)) : longint'(0))) >>> sh;
    if (s) begin
      hi = (longint'(1) <<< (OW - 1)) - 1;
      lo = -(longint'(1) <<< (OW - 1));
      o  = (q > hi) || (q < lo);
      r  = OW'(q);
      r[OW-1] = (q < 0);
      if (SAT && o) r = (q < 0) ? OW'(lo) : OW'(hi);
    end else begin
      o = (q >= (longint'(1) <<< OW));
      r = OW'(q);
      if (SAT && o) r = '1;
    end
    return {o, r};
  endfunction

  task automatic drive_cycle(input logic v, input logic s, input logic [W1-1:0] a,
                             input logic [W2-1:0] b, input logic r,
                             output logic acc, output logic got, output logic rdy,
                             output logic [OW:0] obs, output logic [OW:0] expv);
    @(negedge CLK);
    in_vld = v; sgn = s; in1 = a; in2 = b; out_rdy = r;
    #1;
    rdy  = in_rdy;
    obs  = {ovf, out};
    got  = out_vld && out_rdy;
    acc  = in_vld && in_rdy;
    expv = 'x;
    if (got && exp_q.size() > 0) expv = exp_q.pop_front();
    if (acc) exp_q.push_back(model(s, a, b));
    @(posedge CLK);
  endtask

  task automatic test_reset();
    #2 RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_vld got=%b exp=0", out_vld); end
    checks++; if (out !== '0) begin errors++; $display("[TB] FAIL reset_out got=%h exp=0", out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_rdy got=%b exp=1", in_rdy); end
    RST = 1'b0;
  endtask

  task automatic test_latency();
    @(negedge CLK);
    sgn = 1'b0; in1 = 8'h40; in2 = 8'h60; in_vld = 1'b1; out_rdy = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL lat_in_rdy got=%b exp=1", in_rdy); end
    for (int k = 1; k <= PIP; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      in_vld = 1'b0;
      #1;
      checks++;
      if (out_vld !== (k == PIP)) begin
        errors++; $display("[TB] FAIL lat_out_vld edge=%0d got=%b exp=%b", k, out_vld, (k == PIP));
      end
    end
    checks++; if (out !== 7'h18) begin errors++; $display("[TB] FAIL lat_out got=%h exp=18", out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL lat_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_directed();
    logic [W1-1:0] va [7];
    logic [W2-1:0] vb [7];
    logic          vs [7];
    logic [OW:0]   ve [7];
    logic acc, got, rdy;
    logic [OW:0] obs, expv;
    va = '{8'h40, 8'hC0, 8'h42, 8'hFF, 8'h80, 8'h7F, 8'h80};
    vb = '{8'h60, 8'h60, 8'h40, 8'hFF, 8'h80, 8'h7F, 8'h7F};
    vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ve = '{{1'b0, 7'h18}, {1'b0, 7'h68},
           {1'b0, (RND != 0) ? 7'h11 : 7'h10},
           {1'b1, SAT ? 7'h7F : 7'h7E},
           {1'b1, SAT ? 7'h3F : 7'h00},
           {1'b0, 7'h3F}, {1'b0, 7'h40}};
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1'b1, vs[i], va[i], vb[i], 1'b1, acc, got, rdy, obs, expv);
      got = 1'b0;
      for (int t = 0; t < 12 && !got; t++)
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, got, rdy, obs, expv);
      checks++;
      if (!got) begin
        errors++; $display("[TB] FAIL dir_timeout vec=%0d got=no_result exp=result", i);
      end else begin
        if (obs !== ve[i]) begin
          errors++; $display("[TB] FAIL dir_const vec=%0d got=%h exp=%h", i, obs, ve[i]);
        end
        checks++;
        if (obs !== expv) begin
          errors++; $display("[TB] FAIL dir_model vec=%0d got=%h exp=%h", i, obs, expv);
        end
      end
    end
  endtask

  function automatic logic [7:0] pick(input int sel);
    case (sel)
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic acc, got, rdy;
    logic [OW:0] obs, expv;
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  pick($urandom_range(0, 9)), pick($urandom_range(0, 9)),
                  $urandom_range(0, 3) != 0, acc, got, rdy, obs, expv);
      if (got) begin
        checks++;
        if (obs !== expv) begin errors++; $display("[TB] FAIL rand_result cyc=%0d got=%h exp=%h", i, obs, expv); end
      end
    end
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, got, rdy, obs, expv);
      if (got) begin
        checks++;
        if (obs !== expv) begin errors++; $display("[TB] FAIL rand_drain got=%h exp=%h", obs, expv); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rand_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic acc, got, rdy, r;
    logic [OW:0] obs, expv, held;
    int sent, recv;
    sent = 0; recv = 0; held = '0;
    for (int c = 0; c < 40; c++) begin
      r = !(c >= 6 && c < 11);
      drive_cycle(sent < 8, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), r,
                  acc, got, rdy, obs, expv);
      if (acc) sent++;
      if (c == 6) held = obs;
      if (c >= 6 && c < 11) begin
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_rdy cyc=%0d got=%b exp=0", c, rdy); end
        checks++;
        if (obs !== held) begin errors++; $display("[TB] FAIL bp_out_stable cyc=%0d got=%h exp=%h", c, obs, held); end
      end
      if (got) begin
        recv++;
        checks++;
        if (obs !== expv) begin errors++; $display("[TB] FAIL bp_result cyc=%0d got=%h exp=%h", c, obs, expv); end
      end
    end
    checks++;
    if (recv != 8) begin errors++; $display("[TB] FAIL bp_count got=%0d exp=8", recv); end
  endtask

  task automatic test_reset_midstream();
    logic acc, got, rdy;
    logic [OW:0] obs, expv;
    for (int c = 0; c < 5; c++)
      drive_cycle(c < 3, 1'b0, 8'h40, 8'h60, 1'b0, acc, got, rdy, obs, expv);
    @(negedge CLK);
    #1;
    checks++;
    if (out_vld !== 1'b1) begin errors++; $display("[TB] FAIL mid_held_vld got=%b exp=1", out_vld); end
    RST = 1'b1;
    #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_vld got=%b exp=0", out_vld); end
    checks++; if (out !== '0) begin errors++; $display("[TB] FAIL mid_rst_out got=%h exp=0", out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ovf got=%b exp=0", ovf); end
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, got, rdy, obs, expv);
      checks++;
      if (got) begin errors++; $display("[TB] FAIL mid_stale cyc=%0d got=%h exp=none", c, obs); end
    end
    drive_cycle(1'b1, 1'b0, 8'h42, 8'h40, 1'b1, acc, got, rdy, obs, expv);
    got = 1'b0;
    for (int t = 0; t < 12 && !got; t++)
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, got, rdy, obs, expv);
    checks++;
    if (!got) begin
      errors++; $display("[TB] FAIL mid_fresh_timeout got=no_result exp=result");
    end else if (obs !== expv) begin
      errors++; $display("[TB] FAIL mid_fresh got=%h exp=%h", obs, expv);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
